// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single MemoryUnit access port between the CPU data
// port (p0), the CPU instruction-fetch port (p1) and the DMA/boot-copy
// engine (p2). One request is latched at a time. The arbiter drives the
// MemoryUnit start/busy handshake and returns the read word with a one-cycle
// ack to the winning port.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration. Without it,
// fixed priority p0 > p1 > p2 is used.
//
// Ports:
//   clk, reset                  clock (posedge) and async active-low reset
//   pN_req/addr/data/we (N=0..2) request level plus payload, sampled on grant
//   pN_ack, pN_q                one-cycle completion pulse and held read data
//   mem_addr/data/we/start      request side of the MemoryUnit port
//   mem_busy, mem_q, mem_initDone  MemoryUnit status and read data
//   active                      high whenever the arbiter is not idle
//   grant_id                    port currently or last served
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic [26:0] p0_addr,
    input  logic [31:0] p0_data,
    input  logic        p0_we,
    output logic        p0_ack,
    output logic [31:0] p0_q,
    input  logic        p1_req,
    input  logic [26:0] p1_addr,
    input  logic [31:0] p1_data,
    input  logic        p1_we,
    output logic        p1_ack,
    output logic [31:0] p1_q,
    input  logic        p2_req,
    input  logic [26:0] p2_addr,
    input  logic [31:0] p2_data,
    input  logic        p2_we,
    output logic        p2_ack,
    output logic [31:0] p2_q,
    output logic [26:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_we,
    output logic        mem_start,
    input  logic        mem_busy,
    input  logic [31:0] mem_q,
    input  logic        mem_initDone,
    output logic        active,
    output logic [1:0]  grant_id
);

    localparam int unsigned AW = 27;
    localparam int unsigned DW = 32;
    localparam int unsigned NP = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NP-1:0]        req;
    logic                 win_valid;
    logic [1:0]           win_id;
    logic                 grant;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_data;
    logic                 sel_we;
    logic [AW-1:0]        addr_d;
    logic [DW-1:0]        data_d;
    logic                 we_d;
    logic                 start_d;
    logic [1:0]           gid_d;
    logic [NP-1:0]        ack_q, ack_d;
    logic [NP-1:0][DW-1:0] q_q, q_d;

    assign req = {p2_req, p1_req, p0_req};

`ifdef MEM_ARB_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] rr_idx;

    // Round-robin: search starts at the port after the last granted one.
    always_comb begin
        win_valid = 1'b0;
        win_id    = 2'd0;
        rr_idx    = rr_ptr;
        for (int k = 0; k < 3; k++) begin
            rr_idx = (rr_idx == 2'd2) ? 2'd0 : rr_idx + 2'd1;
            if (!win_valid && req[rr_idx]) begin
                win_valid = 1'b1;
                win_id    = rr_idx;
            end
        end
    end

    // Pointer follows the granted port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 2'd2;
        end else if (grant) begin
            rr_ptr <= win_id;
        end
    end
`else
    // Fixed priority: p0 > p1 > p2.
    always_comb begin
        win_valid = |req;
        win_id    = 2'd2;
        if (req[0]) begin
            win_id = 2'd0;
        end else if (req[1]) begin
            win_id = 2'd1;
        end
    end
`endif

    // Stale busy (e.g. after a reset mid-access) blocks new grants.
    assign grant = (state_q == ST_IDLE) && mem_initDone && !mem_busy && win_valid;

    // Winner payload mux.
    always_comb begin
        case (win_id)
            2'd0: begin
                sel_addr = p0_addr;
                sel_data = p0_data;
                sel_we   = p0_we;
            end
            2'd1: begin
                sel_addr = p1_addr;
                sel_data = p1_data;
                sel_we   = p1_we;
            end
            default: begin
                sel_addr = p2_addr;
                sel_data = p2_data;
                sel_we   = p2_we;
            end
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        addr_d  = mem_addr;
        data_d  = mem_data;
        we_d    = mem_we;
        start_d = mem_start;
        gid_d   = grant_id;
        ack_d   = '0;
        q_d     = q_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    we_d    = sel_we;
                    start_d = 1'b1;
                    gid_d   = win_id;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // start drops on the same edge that sees busy low, so the
                // MemoryUnit cannot re-trigger on the following negedge.
                if (!mem_busy) begin
                    start_d         = 1'b0;
                    we_d            = 1'b0;
                    addr_d          = '0;
                    data_d          = '0;
                    ack_d[grant_id] = 1'b1;
                    q_d[grant_id]   = mem_q;
                    state_d         = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_we    <= 1'b0;
            mem_start <= 1'b0;
            grant_id  <= 2'd2;
            active    <= 1'b0;
            ack_q     <= '0;
            q_q       <= '0;
        end else begin
            state_q   <= state_d;
            mem_addr  <= addr_d;
            mem_data  <= data_d;
            mem_we    <= we_d;
            mem_start <= start_d;
            grant_id  <= gid_d;
            active    <= (state_d != ST_IDLE);
            ack_q     <= ack_d;
            q_q       <= q_d;
        end
    end

    assign p0_ack = ack_q[0];
    assign p1_ack = ack_q[1];
    assign p2_ack = ack_q[2];
    assign p0_q   = q_q[0];
    assign p1_q   = q_q[1];
    assign p2_q   = q_q[2];

endmodule
